// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI request arbiter.
// The FSM state encoding is shared with anything that needs to decode the arbiter phase.
package spi_arb_pkg;

    localparam int unsigned DEF_DATA_W  = 12;
    localparam int unsigned DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LAUNCH,
        ARB_ACTIVE,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first valid index at or above ptr, wrapping past NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_valid,
    output logic [IDX_W-1:0]   grant
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one spi_master between NUM_REQ requesters.
// It launches one frame at a time and brackets it using the master's chip select.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        spi_cs,
    output logic                        newd,
    output logic [DATA_W-1:0]           din,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        xfer_done,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_q;
    logic             cs_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic             any_valid;
    logic [IDX_W-1:0] pick;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .any_valid (any_valid),
        .grant     (pick)
    );

    // Timeout fires on the edge where the phase counter would reach TIMEOUT.
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign cnt_hit = (cnt_inc == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            cs_q        <= 1'b1;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            req_ready   <= '0;
            newd        <= 1'b0;
            din         <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            xfer_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cs_q        <= spi_cs;
            req_ready   <= '0;
            xfer_done   <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_valid) begin
                        din       <= req_data[32'(pick) * DATA_W +: DATA_W];
                        grant_id  <= pick;
                        req_ready <= NUM_REQ'(1) << pick;
                        newd      <= 1'b1;
                        busy      <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ARB_LAUNCH;
                    end
                end
                ARB_LAUNCH: begin
                    if (!cs_q) begin
                        newd    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ARB_ACTIVE;
                    end else if (cnt_hit) begin
                        newd        <= 1'b0;
                        timeout_err <= 1'b1;
                        state_q     <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ARB_ACTIVE: begin
                    if (cs_q) begin
                        xfer_done <= 1'b1;
                        state_q   <= ARB_DONE;
                    end else if (cnt_hit) begin
                        timeout_err <= 1'b1;
                        state_q     <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ARB_DONE: begin
                    // Advance past the last grant even after a timeout so nobody starves.
                    rr_ptr_q <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                    busy     <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule
